// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer: ALU op codes,
// FSM state encoding and iteration sizing.
package alu_mul_seq_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_SLL   = 3'b011,
    OP_SLTIU = 3'b100,
    OP_LUI   = 3'b101,
    OP_SUB   = 3'b110,
    OP_SLT   = 3'b111
  } aluop_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NEGA = 3'd1,
    S_NEGB = 3'd2,
    S_ITER = 3'd3,
    S_FIXL = 3'd4,
    S_FIXH = 3'd5,
    S_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add 32x32->64 multiplier that borrows the execute-stage ALU for every
// add/subtract; signed operands are handled by sign-magnitude conversion.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sign,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic [W-1:0] alu_A,
  output logic [W-1:0] alu_B,
  output logic [2:0]   alu_ALUop,
  input  logic [W-1:0] alu_Result,
  input  logic         alu_CarryOut
);

  state_e           state;
  logic [W-1:0]     mcand;
  logic [CNT_W-1:0] cnt;
  logic             neg_res;
  logic             neg_b;
  logic             brw;

  // ALU operand steering; IDLE/DONE park the ALU on a harmless 0+0
  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = OP_ADD;
    case (state)
      S_NEGA: begin
        alu_B     = mcand;
        alu_ALUop = OP_SUB;
      end
      S_NEGB, S_FIXL: begin
        alu_B     = lo;
        alu_ALUop = OP_SUB;
      end
      S_ITER: begin
        alu_A = hi;
        alu_B = mcand;
      end
      S_FIXH: begin
        alu_A = ~hi;
        alu_B = {{(W-1){1'b0}}, brw};
      end
      default: ;
    endcase
  end

  // Sequencer and datapath registers; lo doubles as the multiplier shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_b   <= 1'b0;
      brw     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand   <= a;
            lo      <= b;
            hi      <= '0;
            cnt     <= CNT_W'(ITERS);
            neg_res <= sign & (a[W-1] ^ b[W-1]);
            neg_b   <= sign & b[W-1];
            busy    <= 1'b1;
            if (sign & a[W-1])      state <= S_NEGA;
            else if (sign & b[W-1]) state <= S_NEGB;
            else                    state <= S_ITER;
          end
        end
        S_NEGA: begin
          mcand <= alu_Result;
          state <= neg_b ? S_NEGB : S_ITER;
        end
        S_NEGB: begin
          lo    <= alu_Result;
          state <= S_ITER;
        end
        S_ITER: begin
          if (lo[0]) {hi, lo} <= {alu_CarryOut, alu_Result, lo[W-1:1]};
          else       {hi, lo} <= {1'b0, hi, lo[W-1:1]};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (neg_res) begin
              state <= S_FIXL;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_FIXL: begin
          lo    <= alu_Result;
          brw   <= alu_CarryOut;
          state <= S_FIXH;
        end
        S_FIXH: begin
          hi    <= alu_Result;
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural 32-bit ALU attached.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_ALUop;
  logic [31:0] alu_Result;
  logic        alu_CarryOut;

  int n_assert = 0;
  int n_fail   = 0;

  alu_mul_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sign         (sign),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_ALUop    (alu_ALUop),
    .alu_Result   (alu_Result),
    .alu_CarryOut (alu_CarryOut)
  );

  // Execute-stage ALU: carry is the raw carry-out of A+B or A+~B+1
  always_comb begin
    alu_Result   = '0;
    alu_CarryOut = 1'b0;
    case (alu_ALUop)
      3'b000: alu_Result = alu_A & alu_B;
      3'b001: alu_Result = alu_A | alu_B;
      3'b010: {alu_CarryOut, alu_Result} = {1'b0, alu_A} + {1'b0, alu_B};
      3'b110: {alu_CarryOut, alu_Result} = {1'b0, alu_A} + {1'b0, ~alu_B} + 33'd1;
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one sampling edge (cycle 0); returns at cycle 1 + 1ns
  task automatic launch(input logic s, input logic [31:0] aa, input logic [31:0] bb);
    sign  = s;
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // From cycle 1, step until done (bounded); reports the cycle done was seen
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 80) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] aa,
                     input logic [31:0] bb, input int exp_cyc, input logic [63:0] exp_p);
    int cyc;
    bit busy_ok;
    launch(s, aa, bb);
    wait_done(cyc, busy_ok);
    chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, " busy_before_done"}, 64'(busy_ok), 64'd1);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd1);
    chk({tag, " product"}, {hi, lo}, exp_p);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_end"}, 64'(done), 64'd0);
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    chk({tag, " product_hold"}, {hi, lo}, exp_p);
  endtask

  initial begin
    int  cyc;
    bit  busy_ok;
    rst   = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", {hi, lo}, 64'd0);
    chk("reset aluop", 64'(alu_ALUop), 64'd2);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("u_ffff_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001);
    run("s_m3x5",    1'b1, 32'hFFFF_FFFD, 32'd5,         36, 64'hFFFF_FFFF_FFFF_FFF1);
    run("s_min_sq",  1'b1, 32'h8000_0000, 32'h8000_0000, 35, 64'h4000_0000_0000_0000);
    run("s_m7x0",    1'b1, 32'hFFFF_FFF9, 32'd0,         36, 64'd0);
    run("s_6xm7",    1'b1, 32'd6,         32'hFFFF_FFF9, 36, 64'hFFFF_FFFF_FFFF_FFD6);

    // Starts during ITER (cycle 5) and DONE (cycle 33) must be ignored
    launch(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int k = 1; k <= 33; k++) begin
      if (k == 20) chk("ign busy_mid", 64'(busy), 64'd1);
      if (k == 33) begin
        chk("ign done_at_33", 64'(done), 64'd1);
        chk("ign product", {hi, lo}, 64'h0B00_EA4E_242D_2080);
      end
      a     = 32'd1;
      b     = 32'd1;
      sign  = 1'b0;
      start = (k == 5) || (k == 33);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("ign idle_at_34", 64'(busy), 64'd0);
    chk("ign hold_at_34", {hi, lo}, 64'h0B00_EA4E_242D_2080);
    launch(1'b0, 32'd2, 32'd3);
    chk("ign accepted_34", 64'(busy), 64'd1);
    wait_done(cyc, busy_ok);
    chk("ign2 done_cycle", 64'(cyc), 64'd33);
    chk("ign2 product", {hi, lo}, 64'd6);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-ITER clears everything without waiting for an edge
    launch(1'b0, 32'hFFFF_FFFF, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst product", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run("arst_6x7", 1'b0, 32'd6, 32'd7, 33, 64'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
